// File: rtl/noc_params.sv
// Shared NoC router parameters and types for the switch allocator slice.
// Pure declarations: no logic, no latency.
// No flow control of its own; consumers size ports and counters from here.
package noc_params;

  localparam int PORT_NUM    = 5;
  localparam int VC_NUM      = 2;
  localparam int BUFFER_SIZE = 8;

  localparam int SEL_SIZE  = $clog2(PORT_NUM);
  localparam int VC_SIZE   = $clog2(VC_NUM);
  localparam int CRED_SIZE = $clog2(BUFFER_SIZE + 1);

  typedef logic [SEL_SIZE-1:0]  port_t;
  typedef logic [VC_SIZE-1:0]   vc_t;
  typedef logic [CRED_SIZE-1:0] cred_t;

endpackage

// File: rtl/switch_allocator_if.sv
// Bundle between input buffers/credit return and the switch allocator.
// Wires only; allocator results appear one cycle after the requests.
// Credit-based: downstream returns credits here, no ready signal exists.
interface switch_allocator_if;
  import noc_params::*;

  logic  [PORT_NUM-1:0][VC_NUM-1:0] request_i;
  port_t [PORT_NUM-1:0][VC_NUM-1:0] out_port_i;
  vc_t   [PORT_NUM-1:0][VC_NUM-1:0] ds_vc_i;
  logic  [PORT_NUM-1:0]             credit_valid_i;
  vc_t   [PORT_NUM-1:0]             credit_vc_i;
  logic  [PORT_NUM-1:0][VC_NUM-1:0] grant_o;
  port_t [PORT_NUM-1:0]             sel_o;
  logic  [PORT_NUM-1:0]             valid_sel_o;

  // Upstream side: input buffers, route/VC state and credit return
  modport master (
    output request_i, out_port_i, ds_vc_i, credit_valid_i, credit_vc_i,
    input  grant_o, sel_o, valid_sel_o
  );

  // Allocator side
  modport slave (
    input  request_i, out_port_i, ds_vc_i, credit_valid_i, credit_vc_i,
    output grant_o, sel_o, valid_sel_o
  );

endinterface

// File: rtl/round_robin_arbiter.sv
// N-way round-robin arbiter: one-hot grant starting the search at the pointer.
// Grant is combinational; pointer moves to winner+1 at the clock edge.
// Pointer holds when update_i is low or nothing is requested.
module round_robin_arbiter #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] requests_i,
  input  logic         update_i,
  output logic [N-1:0] grants_o
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_win;
  logic [PW-1:0] w_idx;
  logic          w_found;
  int            w_pos;

  // Search requests in priority order starting at the pointer
  always_comb begin
    grants_o = '0;
    w_found  = 1'b0;
    w_win    = '0;
    w_idx    = '0;
    w_pos    = 0;
    for (int k = 0; k < N; k++) begin
      w_pos = int'(r_ptr) + k;
      if (w_pos >= N) w_pos = w_pos - N;
      w_idx = PW'(w_pos);
      if (!w_found && requests_i[w_idx]) begin
        grants_o[w_idx] = 1'b1;
        w_found         = 1'b1;
        w_win           = w_idx;
      end
    end
  end

  // Advance the pointer past the winner so it gets lowest priority next
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr <= '0;
    end else if (update_i && w_found) begin
      r_ptr <= (w_win == PW'(N - 1)) ? '0 : w_win + 1'b1;
    end
  end

endmodule

// File: rtl/switch_allocator.sv
// Separable input-first switch allocator with per-output/per-VC credit tracking.
// Requests in cycle t produce registered grant_o/sel_o/valid_sel_o in cycle t+1.
// Credit-gated: a VC competes only while its downstream VC has a free slot.
// Optional macro SWITCH_ALLOC_ISLIP_EN: stage-1 pointers move only on a final win.
module switch_allocator
  import noc_params::*;
(
  input  logic               clk,
  input  logic               rst,
  switch_allocator_if.slave  sa_if
);

  cred_t r_credit [PORT_NUM][VC_NUM];
  logic  [PORT_NUM-1:0][VC_NUM-1:0]   r_grant;
  port_t [PORT_NUM-1:0]               r_sel;
  logic  [PORT_NUM-1:0]               r_vsel;

  logic  [PORT_NUM-1:0][VC_NUM-1:0]   w_elig;
  logic  [PORT_NUM-1:0][VC_NUM-1:0]   w_s1_gnt;
  logic  [PORT_NUM-1:0]               w_s1_vld;
  logic  [PORT_NUM-1:0]               w_s1_upd;
  port_t [PORT_NUM-1:0]               w_s1_port;
  vc_t   [PORT_NUM-1:0]               w_s1_vc;
  logic  [PORT_NUM-1:0][PORT_NUM-1:0] w_s2_req;
  logic  [PORT_NUM-1:0][PORT_NUM-1:0] w_s2_gnt;
  logic  [PORT_NUM-1:0]               w_in_acc;
  logic  [PORT_NUM-1:0][VC_NUM-1:0]   w_grant;
  port_t [PORT_NUM-1:0]               w_sel;
  logic  [PORT_NUM-1:0][VC_NUM-1:0]   w_inc;
  logic  [PORT_NUM-1:0][VC_NUM-1:0]   w_dec;
  cred_t w_cred_nxt [PORT_NUM][VC_NUM];
  logic  w_ovf;

  // A VC may compete only if its routed output/downstream VC still has credit
  always_comb begin
    for (int i = 0; i < PORT_NUM; i++) begin
      for (int v = 0; v < VC_NUM; v++) begin
        w_elig[i][v] = sa_if.request_i[i][v] &&
                       (int'(sa_if.out_port_i[i][v]) < PORT_NUM) &&
                       (r_credit[sa_if.out_port_i[i][v]][sa_if.ds_vc_i[i][v]] != '0);
      end
    end
  end

`ifdef SWITCH_ALLOC_ISLIP_EN
  assign w_s1_upd = w_in_acc;
`else
  assign w_s1_upd = '1;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < PORT_NUM; gi++) begin : g_stage1
      round_robin_arbiter #(.N(VC_NUM)) u_vc_arb (
        .clk        (clk),
        .rst        (rst),
        .requests_i (w_elig[gi]),
        .update_i   (w_s1_upd[gi]),
        .grants_o   (w_s1_gnt[gi])
      );
      assign w_s1_vld[gi] = |w_s1_gnt[gi];
    end
    for (gi = 0; gi < PORT_NUM; gi++) begin : g_stage2
      for (genvar gj = 0; gj < PORT_NUM; gj++) begin : g_req
        assign w_s2_req[gi][gj] = w_s1_vld[gj] && (w_s1_port[gj] == port_t'(gi));
      end
      round_robin_arbiter #(.N(PORT_NUM)) u_port_arb (
        .clk        (clk),
        .rst        (rst),
        .requests_i (w_s2_req[gi]),
        .update_i   (1'b1),
        .grants_o   (w_s2_gnt[gi])
      );
    end
  endgenerate

  // Route/VC of each input's stage-1 winner
  always_comb begin
    for (int i = 0; i < PORT_NUM; i++) begin
      w_s1_port[i] = '0;
      w_s1_vc[i]   = '0;
      for (int v = 0; v < VC_NUM; v++) begin
        if (w_s1_gnt[i][v]) begin
          w_s1_port[i] = sa_if.out_port_i[i][v];
          w_s1_vc[i]   = sa_if.ds_vc_i[i][v];
        end
      end
    end
  end

  // Fold stage-2 results into per-input acceptance, final grants and crossbar selects
  always_comb begin
    w_in_acc = '0;
    for (int o = 0; o < PORT_NUM; o++) begin
      w_sel[o] = '0;
      for (int i = 0; i < PORT_NUM; i++) begin
        if (w_s2_gnt[o][i]) begin
          w_in_acc[i] = 1'b1;
          w_sel[o]    = port_t'(i);
        end
      end
    end
    for (int i = 0; i < PORT_NUM; i++) begin
      w_grant[i] = w_in_acc[i] ? w_s1_gnt[i] : '0;
    end
  end

  // Credit bookkeeping: grant consumes, return refills, both at once cancel
  always_comb begin
    w_ovf = 1'b0;
    for (int o = 0; o < PORT_NUM; o++) begin
      for (int v = 0; v < VC_NUM; v++) begin
        w_dec[o][v] = 1'b0;
        for (int i = 0; i < PORT_NUM; i++) begin
          if (w_in_acc[i] && (w_s1_port[i] == port_t'(o)) && (w_s1_vc[i] == vc_t'(v)))
            w_dec[o][v] = 1'b1;
        end
        w_inc[o][v] = sa_if.credit_valid_i[o] && (sa_if.credit_vc_i[o] == vc_t'(v));
        w_cred_nxt[o][v] = r_credit[o][v];
        if (w_inc[o][v] && !w_dec[o][v]) begin
          if (r_credit[o][v] == cred_t'(BUFFER_SIZE)) w_ovf = 1'b1;
          else w_cred_nxt[o][v] = r_credit[o][v] + 1'b1;
        end else if (w_dec[o][v] && !w_inc[o][v]) begin
          w_cred_nxt[o][v] = r_credit[o][v] - 1'b1;
        end
      end
    end
  end

  // Register allocation results and credit counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_grant <= '0;
      r_sel   <= '0;
      r_vsel  <= '0;
      for (int o = 0; o < PORT_NUM; o++)
        for (int v = 0; v < VC_NUM; v++)
          r_credit[o][v] <= cred_t'(BUFFER_SIZE);
    end else begin
      r_grant  <= w_grant;
      r_sel    <= w_sel;
      for (int o = 0; o < PORT_NUM; o++) begin
        r_vsel[o] <= |w_s2_gnt[o];
        for (int v = 0; v < VC_NUM; v++)
          r_credit[o][v] <= w_cred_nxt[o][v];
      end
    end
  end

  assign sa_if.grant_o     = r_grant;
  assign sa_if.sel_o       = r_sel;
  assign sa_if.valid_sel_o = r_vsel;

  // A credit returned to an already-full counter means upstream lost track
  a_no_credit_overflow: assert property (@(posedge clk) disable iff (!rst) !w_ovf);

endmodule

// File: tb/tb_switch_allocator.sv
// Directed bench for switch_allocator with hand-computed expectations.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
// Credit return is driven directly; no downstream model beyond that.
module tb_switch_allocator;
  import noc_params::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cnt;

  switch_allocator_if sa_if ();

  switch_allocator dut (
    .clk   (clk),
    .rst   (rst),
    .sa_if (sa_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    sa_if.request_i      = '0;
    sa_if.out_port_i     = '0;
    sa_if.ds_vc_i        = '0;
    sa_if.credit_valid_i = '0;
    sa_if.credit_vc_i    = '0;
  endtask

  task automatic do_reset();
    #1;
    rst = 1'b0;
    #1;
    check("rst_grant", 32'(sa_if.grant_o), 32'h0);
    check("rst_vsel", 32'(sa_if.valid_sel_o), 32'h0);
    check("rst_sel", 32'(sa_if.sel_o), 32'h0);
    clear_inputs();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    clear_inputs();
    #2;
    // Test 1: reset state and idle
    do_reset();
    step();
    step();
    check("idle_grant", 32'(sa_if.grant_o), 32'h0);
    check("idle_vsel", 32'(sa_if.valid_sel_o), 32'h0);

    // Test 2: permutation, no conflicts
    for (int i = 0; i < PORT_NUM; i++) begin
      sa_if.request_i[i][0]  = 1'b1;
      sa_if.out_port_i[i][0] = port_t'((i + 1) % PORT_NUM);
    end
    step();
    check("perm_grant", 32'(sa_if.grant_o), 32'h155);
    check("perm_vsel", 32'(sa_if.valid_sel_o), 32'h1f);
    for (int o = 0; o < PORT_NUM; o++) begin
      check($sformatf("perm_sel%0d", o), 32'(sa_if.sel_o[o]), 32'((o + 4) % PORT_NUM));
      check($sformatf("perm_xbar%0d", o), 32'h0A0 + 32'(sa_if.sel_o[o]),
            32'h0A0 + 32'((o + 4) % PORT_NUM));
    end

    // Test 3: three inputs fight for output 3
    do_reset();
    for (int i = 0; i < 3; i++) begin
      sa_if.request_i[i][0]  = 1'b1;
      sa_if.out_port_i[i][0] = port_t'(3);
    end
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("conf_sel_c%0d", k), 32'(sa_if.sel_o[3]), 32'(k % 3));
      check($sformatf("conf_grant_c%0d", k), 32'(sa_if.grant_o), 32'h1 << (2 * (k % 3)));
      check($sformatf("conf_vsel_c%0d", k), 32'(sa_if.valid_sel_o), 32'h08);
    end

    // Test 4: credit exhaustion on port 4 / ds_vc 0, then one credit back
    do_reset();
    sa_if.request_i[0][0]  = 1'b1;
    sa_if.out_port_i[0][0] = port_t'(4);
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      check($sformatf("exh_grant_c%0d", k), 32'(sa_if.grant_o[0]), (k < 8) ? 32'h1 : 32'h0);
      if (sa_if.grant_o[0] != '0) cnt++;
    end
    check("exh_total", 32'(cnt), 32'd8);
    sa_if.credit_valid_i[4] = 1'b1;
    sa_if.credit_vc_i[4]    = '0;
    step();
    sa_if.credit_valid_i[4] = 1'b0;
    check("ret_same_cycle", 32'(sa_if.grant_o[0]), 32'h0);
    cnt = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      if (sa_if.grant_o[0] != '0) cnt++;
    end
    check("ret_total", 32'(cnt), 32'd1);

    // Test 5: grant and credit return on the same counter every cycle
    do_reset();
    sa_if.request_i[1][1]   = 1'b1;
    sa_if.out_port_i[1][1]  = port_t'(2);
    sa_if.ds_vc_i[1][1]     = vc_t'(1);
    sa_if.credit_valid_i[2] = 1'b1;
    sa_if.credit_vc_i[2]    = vc_t'(1);
    for (int k = 0; k < 20; k++) begin
      step();
      check($sformatf("simul_grant_c%0d", k), 32'(sa_if.grant_o), 32'h008);
    end
    sa_if.credit_valid_i[2] = 1'b0;
    cnt = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (sa_if.grant_o[1] != '0) cnt++;
    end
    check("simul_residual", 32'(cnt), 32'd8);

    // Test 6: VC round-robin inside input 2
    do_reset();
    sa_if.request_i[2]     = 2'b11;
    sa_if.out_port_i[2][0] = port_t'(0);
    sa_if.out_port_i[2][1] = port_t'(1);
    for (int k = 0; k < 6; k++) begin
      step();
      check($sformatf("vcrr_grant_c%0d", k), 32'(sa_if.grant_o), (k % 2 == 0) ? 32'h010 : 32'h020);
      check($sformatf("vcrr_vsel_c%0d", k), 32'(sa_if.valid_sel_o), (k % 2 == 0) ? 32'h01 : 32'h02);
    end

    // Test 7: input 2 VC1 loses output 1 in stage 2; pointer policy decides the retry
    do_reset();
    sa_if.request_i[0][0]  = 1'b1;
    sa_if.out_port_i[0][0] = port_t'(1);
    sa_if.request_i[1][0]  = 1'b1;
    sa_if.out_port_i[1][0] = port_t'(1);
    sa_if.request_i[2]     = 2'b11;
    sa_if.out_port_i[2][0] = port_t'(0);
    sa_if.out_port_i[2][1] = port_t'(1);
    step();
    check("blk_grant_c0", 32'(sa_if.grant_o), 32'h011);
    check("blk_sel1_c0", 32'(sa_if.sel_o[1]), 32'd0);
    step();
    check("blk_grant_c1", 32'(sa_if.grant_o), 32'h004);
    check("blk_sel1_c1", 32'(sa_if.sel_o[1]), 32'd1);
    step();
`ifdef SWITCH_ALLOC_ISLIP_EN
    check("blk_grant_c2", 32'(sa_if.grant_o), 32'h020);
    check("blk_sel1_c2", 32'(sa_if.sel_o[1]), 32'd2);
`else
    check("blk_grant_c2", 32'(sa_if.grant_o), 32'h011);
    check("blk_sel1_c2", 32'(sa_if.sel_o[1]), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
